uart_tx_engine: RTL and testbench

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_gen.sv | 21 ++
 rtl/uart_tx_engine.sv | 148 ++++++++++++++
 tb/tb_uart_tx_engine.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd5
    } uart_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: tick when the count reaches div, then wrap to 0.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] r_cnt;

    assign tick = (r_cnt == div);

    always_ff @(posedge clk) begin
        if (reset || clear || tick) r_cnt <= '0;
        else                        r_cnt <= r_cnt + DIV_W'(1);
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine popping words from a TX FIFO, optional parity.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int DIV_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 txfe,
    input  logic [DATA_BITS-1:0] tx_fifo_data,
    output logic                 tx_fifo_shift,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam logic [3:0] BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

    uart_state_t          r_state;
    logic [DATA_BITS-1:0] r_shreg;
    logic [DIV_W-1:0]     r_div;
    logic [3:0]           r_bit_cnt;
    logic                 r_tx, r_busy, r_shift, r_done;
    logic                 w_tick;

`ifdef UART_TX_PARITY_EN
    logic [1:0] r_par_mode;
    logic       r_par_bit;
    logic       w_par_on;
    assign w_par_on = (r_par_mode == PAR_EVEN) || (r_par_mode == PAR_ODD);
`else
    logic w_unused_par;
    assign w_unused_par = ^parity_mode;
`endif

    // Clearing during LOAD makes the count start at 0 on the first START cycle.
    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (r_state == LOAD),
        .div   (r_div),
        .tick  (w_tick)
    );

    assign tx            = r_tx;
    assign busy          = r_busy;
    assign tx_fifo_shift = r_shift;
    assign tx_done       = r_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_shift   <= 1'b0;
            r_done    <= 1'b0;
            r_shreg   <= '0;
            r_div     <= '0;
            r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            r_par_mode <= PAR_NONE;
            r_par_bit  <= 1'b0;
`endif
        end else begin
            r_shift <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: if (!txfe) begin
                    r_state <= LOAD;
                    r_shift <= 1'b1;
                    r_busy  <= 1'b1;
                end
                LOAD: begin
                    r_shreg   <= tx_fifo_data;
                    r_div     <= baud_div;
`ifdef UART_TX_PARITY_EN
                    r_par_mode <= parity_mode;
                    r_par_bit  <= (^tx_fifo_data) ^ (parity_mode == PAR_ODD);
`endif
                    r_bit_cnt <= '0;
                    r_tx      <= 1'b0;
                    r_state   <= START;
                end
                START: if (w_tick) begin
                    r_tx      <= r_shreg[0];
                    r_bit_cnt <= '0;
                    r_state   <= DATA;
                end
                DATA: if (w_tick) begin
                    if (r_bit_cnt == BIT_LAST) begin
                        r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                        if (w_par_on) begin
                            r_tx    <= r_par_bit;
                            r_state <= PARITY;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end
`else
                        r_tx    <= 1'b1;
                        r_state <= STOP;
`endif
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        r_shreg   <= r_shreg >> 1;
                        r_tx      <= r_shreg[1];
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (w_tick) begin
                    r_tx      <= 1'b1;
                    r_bit_cnt <= '0;
                    r_state   <= STOP;
                end
`endif
                STOP: if (w_tick) begin
                    if (r_bit_cnt == STOP_LAST) begin
                        r_done    <= 1'b1;
                        r_bit_cnt <= '0;
                        // Next word already waiting: skip IDLE so frames abut.
                        if (!txfe) begin
                            r_shift <= 1'b1;
                            r_state <= LOAD;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: table of single frames plus corner sequences.
// Parity expectations follow UART_TX_PARITY_EN.
module tb_uart_tx_engine;
    import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [15:0] baud_div, baud_div5;
    logic [1:0]  parity_mode, parity_mode5;
    logic        txfe, txfe5;
    logic [7:0]  tx_fifo_data;
    logic [4:0]  tx_fifo_data5;
    logic        tx_fifo_shift, tx, busy, tx_done;
    logic        tx_fifo_shift5, tx5, busy5, tx_done5;

    uart_tx_engine dut (
        .clk(clk), .reset(reset), .baud_div(baud_div), .parity_mode(parity_mode),
        .txfe(txfe), .tx_fifo_data(tx_fifo_data), .tx_fifo_shift(tx_fifo_shift),
        .tx(tx), .busy(busy), .tx_done(tx_done)
    );

    uart_tx_engine #(.DATA_BITS(5), .STOP_BITS(2), .DIV_W(16)) dut5 (
        .clk(clk), .reset(reset), .baud_div(baud_div5), .parity_mode(parity_mode5),
        .txfe(txfe5), .tx_fifo_data(tx_fifo_data5), .tx_fifo_shift(tx_fifo_shift5),
        .tx(tx5), .busy(busy5), .tx_done(tx_done5)
    );

    typedef struct {
        logic [7:0]  data;
        logic [15:0] div;
        logic [1:0]  pmode;
        logic        par_sent;
        logic        par_bit;
    } vec_t;

    localparam bit BB [0:20] = '{0,1,1,0,0,0,1,0,1,1, 1, 0,0,0,1,1,1,1,0,0,1};
    localparam bit S5 [0:7]  = '{0,1,1,1,1,1,1,1};

    vec_t       vecs [6];
    logic [7:0] q  [$];
    logic [4:0] q5 [$];
    int errors = 0, checks = 0;
    int pops = 0, pops5 = 0, viol = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic refresh();
        txfe          = (q.size() == 0);
        tx_fifo_data  = (q.size() != 0) ? q[0] : 8'h00;
        txfe5         = (q5.size() == 0);
        tx_fifo_data5 = (q5.size() != 0) ? q5[0] : 5'h00;
    endtask

    // One clock; the FIFO model pops after any cycle that showed the strobe.
    task automatic step();
        logic s, s5;
        s  = tx_fifo_shift;
        s5 = tx_fifo_shift5;
        if ((tx_fifo_shift && txfe) || (tx_fifo_shift5 && txfe5)) viol++;
        @(posedge clk);
        #1;
        if (s && q.size() != 0)   begin void'(q.pop_front());  pops++;  end
        if (s5 && q5.size() != 0) begin void'(q5.pop_front()); pops5++; end
        refresh();
    endtask

    task automatic wait_start(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tx == 1'b0) begin found = 1'b1; break; end
        end
        chk(name, int'(found), 1);
    endtask

    task automatic run_frame(input int idx);
        vec_t v;
        bit   seq [12];
        int   nb, per, total, early;
        v = vecs[idx];
        seq[0] = 1'b0;
        for (int i = 0; i < 8; i++) seq[1+i] = v.data[i];
        nb = 9;
        if (PAR_EN && v.par_sent) begin seq[nb] = v.par_bit; nb++; end
        seq[nb] = 1'b1;
        nb++;
        per   = int'(v.div) + 1;
        total = nb * per;
        early = 0;
        baud_div    = v.div;
        parity_mode = v.pmode;
        q.push_back(v.data);
        refresh();
        wait_start($sformatf("v%0d_start", idx));
        for (int k = 0; k < total; k++) begin
            chk($sformatf("v%0d_tx_c%0d", idx, k), int'(tx), int'(seq[k/per]));
            if (tx_done) early++;
            step();
        end
        chk($sformatf("v%0d_early_done", idx), early, 0);
        chk($sformatf("v%0d_done", idx), int'(tx_done), 1);
        chk($sformatf("v%0d_idle_busy", idx), int'(busy), 0);
        chk($sformatf("v%0d_idle_tx", idx), int'(tx), 1);
        step();
        chk($sformatf("v%0d_done_width", idx), int'(tx_done), 0);
    endtask

    initial begin
        int mark, nd, d1, d2;
        vecs[0] = '{8'h55, 16'd3, PAR_NONE, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 16'd1, PAR_EVEN, 1'b1, 1'b1};
        vecs[2] = '{8'h07, 16'd1, PAR_ODD,  1'b1, 1'b0};
        vecs[3] = '{8'hA3, 16'd0, 2'b11,    1'b0, 1'b0};
        vecs[4] = '{8'hFF, 16'd0, PAR_EVEN, 1'b1, 1'b0};
        vecs[5] = '{8'hC0, 16'd2, PAR_ODD,  1'b1, 1'b1};

        reset = 1'b1; baud_div = '0; parity_mode = PAR_NONE;
        baud_div5 = '0; parity_mode5 = PAR_NONE;
        q.push_back(8'h12); q5.push_back(5'h03);
        refresh();
        step(); step(); step();
        // A pending word must not start a frame while reset is held.
        chk("rst_tx", int'(tx), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_shift", int'(tx_fifo_shift), 0);
        chk("rst_done", int'(tx_done), 0);
        chk("rst5_tx", int'(tx5), 1);
        chk("rst5_busy", int'(busy5), 0);
        q.delete(); q5.delete();
        refresh();
        reset = 1'b0;
        step(); step();
        chk("post_rst_busy", int'(busy), 0);

        for (int i = 0; i < 6; i++) run_frame(i);

        // Back-to-back frames at baud_div=0.
        baud_div = 16'd0; parity_mode = PAR_NONE;
        mark = pops; nd = 0;
        q.push_back(8'hA3); q.push_back(8'h3C);
        refresh();
        wait_start("bb_start");
        for (int k = 0; k < 21; k++) begin
            chk($sformatf("bb_tx_c%0d", k), int'(tx), int'(BB[k]));
            if (k == 10) begin
                chk("bb_done1", int'(tx_done), 1);
                chk("bb_load_after_stop", int'(tx_fifo_shift), 1);
            end
            if (tx_done) nd++;
            step();
        end
        chk("bb_done2", int'(tx_done), 1);
        chk("bb_idle_busy", int'(busy), 0);
        chk("bb_done_count", nd + int'(tx_done), 2);
        chk("bb_pops", pops - mark, 2);
        step();

        // Reset during DATA bit 4 aborts the frame.
        baud_div = 16'd3;
        q.push_back(8'h55);
        refresh();
        wait_start("rm_start");
        for (int k = 0; k < 21; k++) step();
        mark = pops; nd = 0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rm_tx", int'(tx), 1);
        chk("rm_busy", int'(busy), 0);
        for (int k = 0; k < 60; k++) begin
            if (tx_done) nd++;
            step();
        end
        chk("rm_no_done", nd, 0);
        chk("rm_no_pop", pops - mark, 0);

        // Divisor change mid-frame only affects the next frame.
        baud_div = 16'd3;
        q.push_back(8'h55); q.push_back(8'h55);
        refresh();
        nd = 0; d1 = -1; d2 = -1;
        wait_start("bd_start");
        for (int k = 0; k < 130; k++) begin
            if (k == 10) baud_div = 16'd7;
            if (k == 41) chk("bd_f2_start", int'(tx), 0);
            if (k == 48) chk("bd_f2_start_end", int'(tx), 0);
            if (k == 49) chk("bd_f2_bit0", int'(tx), 1);
            if (tx_done) begin
                nd++;
                if (d1 < 0) d1 = k; else d2 = k;
            end
            step();
        end
        chk("bd_done_count", nd, 2);
        chk("bd_done1_cycle", d1, 40);
        chk("bd_done2_cycle", d2, 121);

        // 5 data bits, 2 stop bits.
        baud_div5 = 16'd0;
        q5.push_back(5'h1F);
        refresh();
        begin
            bit found = 1'b0;
            for (int i = 0; i < 20; i++) begin
                step();
                if (tx5 == 1'b0) begin found = 1'b1; break; end
            end
            chk("d5_start", int'(found), 1);
        end
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("d5_tx_c%0d", k), int'(tx5), int'(S5[k]));
            step();
        end
        chk("d5_done", int'(tx_done5), 1);
        chk("d5_idle_busy", int'(busy5), 0);
        chk("d5_idle_tx", int'(tx5), 1);
        chk("d5_pops", pops5, 1);

        chk("no_pop_when_empty", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
